gate_delay_meter: RTL and testbench
===================================

# gate_delay_meter

Measures the timing of a gate pulse relative to its trigger: delay from trigger rising edge to pulse rising edge and pulse high time, both in clock cycles. It is the receive/measurement counterpart of the gate-delay pulse generator. It sits on the experiment-side inputs of the FPGA, either on a loopback path for self-calibration or on external detector gates. Results go to the register/readout logic through a valid/ready handshake.

## Interface
- `W`, 32: width of the counter, the result fields and the timeout value.
- `i_clk` in 1: system clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_trigger` in 1: asynchronous trigger input.
- `i_pulse` in 1: asynchronous gate pulse input.
- `i_timeout` in W: abort limit in cycles after the trigger event. 0 disables the timeout.
- `i_ready` in 1: the consumer accepts the result.
- `o_delay` out W: measured delay in cycles.
- `o_width` out W: measured high time in cycles.
- `o_timeout` out 1: the result was terminated by the timeout.
- `o_overrun` out 1: at least one trigger event was ignored since the last accepted result.
- `o_valid` out 1: result fields are valid.
- `o_busy` out 1: a measurement is in progress (WAIT_RISE or HIGH).

## Operation
- Synchronisation:
  - `i_trigger` and `i_pulse` each pass through a 2-FF synchroniser and then a registered edge detector.
  - The events are: trigger rise (`trg_ev`), pulse rise (`rise_ev`) and pulse fall (`fall_ev`).
  - Both paths have identical latency, so relative timing is preserved exactly.
- Elapsed counter `cnt` (W bits):
  - Cleared to 0 on `trg_ev` in IDLE.
  - Increments by 1 each cycle in WAIT_RISE and HIGH.
  - Saturates at all-ones.
- FSM states: IDLE, WAIT_RISE, HIGH, DONE.
  - **IDLE, `trg_ev`:**
    - If `rise_ev` is in the same cycle: go to HIGH, latch delay = 0.
    - Otherwise: go to WAIT_RISE.
  - **WAIT_RISE, `rise_ev`:** latch delay = `cnt`+1, go to HIGH. The rise event sets the delay even if it coincides with the timeout.
  - **HIGH, `fall_ev`:** latch width = `cnt`+1 − delay, go to DONE. The fall event sets the width even if it coincides with the timeout.
  - **Timeout:** in WAIT_RISE or HIGH, `i_timeout`≠0 and `cnt`+1 == `i_timeout` with no qualifying event that cycle → go to DONE with `o_timeout`=1.
    - From WAIT_RISE: delay = `i_timeout`, width = 0.
    - From HIGH: width = `i_timeout` − delay.
  - **DONE:** `o_valid`=1 and all result outputs held stable. `i_ready`=1 at a clock edge → go to IDLE, `o_valid` drops.
- A pulse already high when the trigger arrives is not measured. Only a subsequent `rise_ev` in WAIT_RISE counts.
- `rise_ev` and `fall_ev` outside their qualifying state are ignored.
- Overrun:
  - `trg_ev` in WAIT_RISE, HIGH or DONE sets the sticky `o_overrun`.
  - Accepting a result clears it.
  - If acceptance and `trg_ev` coincide, set wins.
- Arithmetic is unsigned W-bit, with no wrap: the counter saturates, and the timeout bounds every result.

## Timing
- Reset (asynchronous): state IDLE; `cnt`, synchronisers, edge registers and all outputs are 0.
- Reset mid-measurement aborts immediately. No result is produced.
- Input to event: an input change sampled at edge k shows the event register high after edge k+2.
- Event to result:
  - `fall_ev` (or the timeout) high in cycle n → `o_valid`=1 from cycle n+1.
  - Results and flags are registered and update in the same cycle as `o_valid`.
- `o_busy` is 1 exactly while in WAIT_RISE or HIGH.
- The minimum measurable width is 1 cycle.
- Throughput: the next trigger is accepted one cycle after the handshake completes.

## Structure
- `gate_meter_pkg` holds:
  - the state enum (IDLE, WAIT_RISE, HIGH, DONE);
  - the default counter width constant (32).
- One sub-module, `edge_sync`: 2-FF synchroniser plus rise/fall edge detection with asynchronous reset. It is instantiated twice, once for trigger and once for pulse.
- The FSM, counter and result registers live in the top module.

## Test plan
- **Basic:** trigger rises at cycle 0; pulse rises at cycle 10 and falls at cycle 15; `i_ready`=1 → `o_delay`=10, `o_width`=5, `o_timeout`=0, `o_overrun`=0, `o_valid` for 1 cycle.
- **Coincident:** trigger and pulse rise in the same cycle; pulse high 3 cycles → `o_delay`=0, `o_width`=3.
- **Timeout:** `i_timeout`=20, no pulse → `o_valid` 20 cycles after `trg_ev`, `o_timeout`=1, `o_delay`=20, `o_width`=0. Repeat with pulse delay 8 and pulse stuck high → `o_delay`=8, `o_width`=12, `o_timeout`=1.
- **Handshake/overrun:**
  - Setup: hold `i_ready`=0 after a result; apply a second trigger.
  - Held result: outputs stay stable and `o_overrun`=1.
  - After `i_ready`=1: the next result has `o_overrun`=0, unless a new trigger was ignored.
- **Pre-high pulse:** pulse already high before the trigger; it falls, then rises 6 cycles after the trigger and stays high 4 cycles → `o_delay`=6, `o_width`=4.
- **Reset:** assert `i_rst` in HIGH → immediately IDLE, all outputs 0; no result after release until a new trigger.

Source files
------------

// File: rtl/gate_meter_pkg.sv
// Shared types and constants for the gate delay meter.
package gate_meter_pkg;

    // Default width of the elapsed counter, results and timeout value
    localparam int GATE_METER_W = 32;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a registered rise/fall edge detector.
// Trigger and pulse both go through one of these, so their event latencies
// match and relative timing is preserved.
module edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Stage p0/p1: bring the asynchronous input into the clock domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= i_d;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: registered edge detection on the synchronised level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_p2 <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            prev_p2 <= sync_p1;
            o_rise  <= sync_p1 & ~prev_p2;
            o_fall  <= ~sync_p1 & prev_p2;
        end
    end

endmodule

// File: rtl/gate_delay_meter.sv
// Measures trigger-to-pulse delay and pulse high time in clock cycles and
// presents the result through a valid/ready handshake.
module gate_delay_meter
    import gate_meter_pkg::*;
#(
    parameter int W = GATE_METER_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_trigger,
    input  logic         i_pulse,
    input  logic [W-1:0] i_timeout,
    input  logic         i_ready,
    output logic [W-1:0] o_delay,
    output logic [W-1:0] o_width,
    output logic         o_timeout,
    output logic         o_overrun,
    output logic         o_valid,
    output logic         o_busy
);

    logic         trg_ev;
    logic         trg_fall_unused;
    logic         rise_ev;
    logic         fall_ev;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] delay_q;
    logic         tmo_hit;
    logic         accept;

    // Saturating increment: the counter sticks at all-ones instead of wrapping
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    edge_sync u_trg_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_trigger),
        .o_rise (trg_ev),
        .o_fall (trg_fall_unused)
    );

    edge_sync u_pulse_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_pulse),
        .o_rise (rise_ev),
        .o_fall (fall_ev)
    );

    // Elapsed-count view of the current cycle and the timeout compare
    always_comb begin
        cnt_inc = sat_inc(cnt);
        tmo_hit = (i_timeout != '0) && (cnt_inc == i_timeout);
        accept  = (state == ST_DONE) && i_ready;
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; qualifying edges take priority over the timeout
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (trg_ev)
                    state_nx = rise_ev ? ST_HIGH : ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise_ev)
                    state_nx = ST_HIGH;
                else if (tmo_hit)
                    state_nx = ST_DONE;
            end
            ST_HIGH: begin
                if (fall_ev || tmo_hit)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        o_valid = (state == ST_DONE);
        o_busy  = (state == ST_WAIT_RISE) || (state == ST_HIGH);
    end

    // Counter, latched delay and result registers (loaded on entry to DONE)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            delay_q   <= '0;
            o_delay   <= '0;
            o_width   <= '0;
            o_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trg_ev) begin
                        cnt     <= '0;
                        delay_q <= '0;
                    end
                end
                ST_WAIT_RISE: begin
                    cnt <= cnt_inc;
                    if (rise_ev) begin
                        delay_q <= cnt_inc;
                    end else if (tmo_hit) begin
                        o_delay   <= i_timeout;
                        o_width   <= '0;
                        o_timeout <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    cnt <= cnt_inc;
                    if (fall_ev) begin
                        o_delay   <= delay_q;
                        o_width   <= cnt_inc - delay_q;
                        o_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        o_delay   <= delay_q;
                        o_width   <= i_timeout - delay_q;
                        o_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: an ignored trigger sets it, acceptance clears it, set wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_overrun <= 1'b0;
        else if (trg_ev && (state != ST_IDLE))
            o_overrun <= 1'b1;
        else if (accept)
            o_overrun <= 1'b0;
    end

endmodule

// File: tb/tb_gate_delay_meter.sv
// Directed, table-driven bench for gate_delay_meter.
module tb_gate_delay_meter;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_trigger;
    logic         i_pulse;
    logic [W-1:0] i_timeout;
    logic         i_ready;
    logic [W-1:0] o_delay;
    logic [W-1:0] o_width;
    logic         o_timeout;
    logic         o_overrun;
    logic         o_valid;
    logic         o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    gate_delay_meter #(.W(W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_trigger (i_trigger),
        .i_pulse   (i_pulse),
        .i_timeout (i_timeout),
        .i_ready   (i_ready),
        .o_delay   (o_delay),
        .o_width   (o_width),
        .o_timeout (o_timeout),
        .o_overrun (o_overrun),
        .o_valid   (o_valid),
        .o_busy    (o_busy)
    );

    // One measurement: trigger rises at loop cycle 0, pulse shape relative to it.
    // exp_lat is the loop cycle at which o_valid is first seen.
    typedef struct {
        int    d;
        int    w;
        bit    stuck;
        bit    pre;
        int    pre_fall;
        int    tmo;
        int    exp_delay;
        int    exp_width;
        bit    exp_to;
        int    exp_lat;
        string name;
    } vec_t;

    vec_t vecs[9];
    vec_t hs_vec;

    function automatic vec_t mk(input int d, input int w, input bit stuck, input bit pre,
                                input int pre_fall, input int tmo, input int ed, input int ew,
                                input bit eto, input int elat, input string name);
        vec_t v;
        v.d = d; v.w = w; v.stuck = stuck; v.pre = pre; v.pre_fall = pre_fall;
        v.tmo = tmo; v.exp_delay = ed; v.exp_width = ew; v.exp_to = eto;
        v.exp_lat = elat; v.name = name;
        return v;
    endfunction

    function automatic logic pulse_at(input vec_t v, input int c);
        logic p;
        if (v.stuck)
            p = (c >= v.d);
        else
            p = (c >= v.d) && (c < v.d + v.w);
        if (v.pre && c < v.pre_fall)
            p = 1'b1;
        return p;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_trigger = 1'b0;
        i_pulse   = 1'b0;
        repeat (n) tick();
    endtask

    // Applies a vector and returns the loop cycle where o_valid appeared (-1 if never)
    task automatic run_vec(input vec_t v, output int lat);
        lat       = -1;
        i_timeout = v.tmo;
        if (v.pre) begin
            i_pulse = 1'b1;
            repeat (5) tick();
        end
        for (int c = 0; c < 100; c++) begin
            i_trigger = 1'b1;
            i_pulse   = pulse_at(v, c);
            tick();
            if (o_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input vec_t v, input int lat, input logic exp_ovr);
        check({v.name, ".lat"},     lat,       v.exp_lat);
        check({v.name, ".delay"},   o_delay,   v.exp_delay);
        check({v.name, ".width"},   o_width,   v.exp_width);
        check({v.name, ".timeout"}, o_timeout, v.exp_to);
        check({v.name, ".overrun"}, o_overrun, exp_ovr);
        check({v.name, ".busy"},    o_busy,    1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        vecs[0] = mk(10,    5, 0, 0, 0,  0, 10,  5, 0, 18, "basic");
        vecs[1] = mk( 0,    3, 0, 0, 0,  0,  0,  3, 0,  6, "coincident");
        vecs[2] = mk(1000,  0, 0, 0, 0, 20, 20,  0, 1, 23, "tmo_nopulse");
        vecs[3] = mk( 8,    0, 1, 0, 0, 20,  8, 12, 1, 23, "tmo_stuck");
        vecs[4] = mk( 6,    4, 0, 1, 2,  0,  6,  4, 0, 13, "pre_high");
        vecs[5] = mk( 5,    1, 0, 0, 0,  0,  5,  1, 0,  9, "min_width");
        vecs[6] = mk( 7,    3, 0, 0, 0,  7,  7,  3, 0, 13, "rise_at_tmo");
        vecs[7] = mk( 4,    5, 0, 0, 0,  9,  4,  5, 0, 12, "fall_at_tmo");
        vecs[8] = mk(1000,  0, 0, 0, 0,  1,  1,  0, 1,  4, "tmo_one");
        hs_vec  = mk( 4,    3, 0, 0, 0,  0,  4,  3, 0, 10, "handshake");

        // Reset state
        i_rst     = 1'b1;
        i_trigger = 1'b0;
        i_pulse   = 1'b0;
        i_timeout = '0;
        i_ready   = 1'b1;
        repeat (3) tick();
        check("rst.valid",   o_valid,   1'b0);
        check("rst.busy",    o_busy,    1'b0);
        check("rst.delay",   o_delay,   '0);
        check("rst.width",   o_width,   '0);
        check("rst.timeout", o_timeout, 1'b0);
        check("rst.overrun", o_overrun, 1'b0);
        i_rst = 1'b0;
        idle(4);

        // Table-driven measurements, consumer always ready
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], lat);
            check_result(vecs[i], lat, 1'b0);
            i_pulse = pulse_at(vecs[i], lat + 1);
            tick();
            check({vecs[i].name, ".valid_drop"}, o_valid, 1'b0);
            idle(6);
        end

        // Result held while not ready; a retrigger sets overrun
        i_ready = 1'b0;
        run_vec(hs_vec, lat);
        check_result(hs_vec, lat, 1'b0);
        i_trigger = 1'b0;
        repeat (3) tick();
        check("hold.valid", o_valid, 1'b1);
        check("hold.delay", o_delay, 32'd4);
        i_trigger = 1'b1;
        repeat (4) tick();
        check("hold.valid2",  o_valid,   1'b1);
        check("hold.overrun", o_overrun, 1'b1);
        check("hold.delay2",  o_delay,   32'd4);
        check("hold.width2",  o_width,   32'd3);
        i_ready = 1'b1;
        tick();
        check("accept.valid",   o_valid,   1'b0);
        check("accept.overrun", o_overrun, 1'b0);
        idle(6);
        run_vec(vecs[0], lat);
        check_result(vecs[0], lat, 1'b0);
        tick();
        idle(6);

        // Acceptance in the same cycle as an ignored trigger: overrun stays set
        i_ready = 1'b0;
        run_vec(hs_vec, lat);
        check_result(hs_vec, lat, 1'b0);
        i_trigger = 1'b0;
        repeat (3) tick();
        i_trigger = 1'b1;
        repeat (3) tick();
        i_ready = 1'b1;
        tick();
        check("setwins.valid",   o_valid,   1'b0);
        check("setwins.overrun", o_overrun, 1'b1);
        idle(6);
        run_vec(vecs[0], lat);
        check_result(vecs[0], lat, 1'b1);
        tick();
        check("setwins.cleared", o_overrun, 1'b0);
        idle(6);

        // Asynchronous reset while in HIGH aborts the measurement
        i_timeout = '0;
        i_trigger = 1'b1;
        i_pulse   = 1'b1;
        repeat (6) tick();
        check("midrst.busy_before", o_busy, 1'b1);
        #2;
        i_rst     = 1'b1;
        i_trigger = 1'b0;
        i_pulse   = 1'b0;
        #1;
        check("midrst.busy",    o_busy,    1'b0);
        check("midrst.valid",   o_valid,   1'b0);
        check("midrst.delay",   o_delay,   '0);
        check("midrst.width",   o_width,   '0);
        check("midrst.timeout", o_timeout, 1'b0);
        check("midrst.overrun", o_overrun, 1'b0);
        repeat (3) tick();
        i_rst = 1'b0;
        seen  = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_valid || o_busy) seen++;
        end
        check("midrst.no_result", seen, 0);
        run_vec(vecs[0], lat);
        check_result(vecs[0], lat, 1'b0);
        tick();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
